// File: rtl/mbx_rx_pkg.sv
// Shared types for the mailbox receive endpoint: FSM state encoding and
// the FIFO pointer-width helper.
package mbx_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mbx_rx_endpoint_if.sv
// Producer-side acknowledge handshake and downstream valid/ready sink,
// bundled for the mailbox receive endpoint.
interface mbx_rx_endpoint_if #(
   parameter int DW = 8
);
   logic          gen_valid_i;
   logic [DW-1:0] gen_data_i;
   logic          gen_next_o;
   logic          drv_valid_o;
   logic [DW-1:0] drv_data_o;
   logic          drv_ready_i;

   modport master (
      output gen_valid_i, gen_data_i, drv_ready_i,
      input  gen_next_o, drv_valid_o, drv_data_o
   );

   modport slave (
      input  gen_valid_i, gen_data_i, drv_ready_i,
      output gen_next_o, drv_valid_o, drv_data_o
   );
endinterface

// File: rtl/mbx_rx_fifo.sv
// Show-ahead synchronous FIFO, DEPTH x DW. Full/empty come from the
// pre-pop pointers: a push while full is dropped, a pop while empty is ignored.
module mbx_rx_fifo
   import mbx_rx_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic          full,
   output logic          empty
);
   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Pointer update; reset discards whatever was buffered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end
endmodule

// File: rtl/mbx_rx_endpoint.sv
// Mailbox receive endpoint: accepts NUM_ITEMS words from a producer with a
// one-cycle acknowledge per word, buffers them and forwards to a valid/ready
// sink, then pulses done_o once everything has drained.
// Optional build macro MBX_RX_TIMEOUT_EN adds an idle timeout in RECV.
//
// state | meaning
// IDLE  | waiting for start_i
// RECV  | accepting producer words
// DRAIN | all words in (or timed out), waiting for the FIFO to empty
// DONE  | one-cycle completion, done_o high
module mbx_rx_endpoint
   import mbx_rx_pkg::*;
#(
   parameter int DW        = 8,
   parameter int DEPTH     = 4,
   parameter int NUM_ITEMS = 10,
   parameter int CW        = $clog2(NUM_ITEMS + 1)
`ifdef MBX_RX_TIMEOUT_EN
   , parameter int TIMEOUT = 64
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   mbx_rx_endpoint_if.slave     bus,
   output logic [CW-1:0]        rcv_count_o,
   output logic                 busy_o,
   output logic                 done_o
`ifdef MBX_RX_TIMEOUT_EN
   , output logic               timeout_o
`endif
);
   state_t state;
   logic   fifo_full;
   logic   fifo_empty;
   logic   accept;

   // The !gen_next_o term keeps a held word from being taken twice.
   assign accept = (state == RECV) && bus.gen_valid_i && !fifo_full && !bus.gen_next_o;
   assign bus.drv_valid_o = !fifo_empty;

   mbx_rx_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .wdata (bus.gen_data_i),
      .pop   (bus.drv_ready_i),
      .head  (bus.drv_data_o),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef MBX_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_cnt;
`endif

   // Sequencer FSM with registered acknowledge, status and item count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         bus.gen_next_o <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         rcv_count_o    <= '0;
`ifdef MBX_RX_TIMEOUT_EN
         timeout_o      <= 1'b0;
         idle_cnt       <= '0;
`endif
      end else begin
         bus.gen_next_o <= accept;
         done_o         <= 1'b0;
`ifdef MBX_RX_TIMEOUT_EN
         timeout_o      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start_i) begin
                  state       <= RECV;
                  busy_o      <= 1'b1;
                  rcv_count_o <= '0;
`ifdef MBX_RX_TIMEOUT_EN
                  idle_cnt    <= '0;
`endif
               end
            end
            RECV: begin
               if (accept) begin
                  rcv_count_o <= rcv_count_o + CW'(1);
                  if (rcv_count_o == CW'(NUM_ITEMS - 1)) state <= DRAIN;
`ifdef MBX_RX_TIMEOUT_EN
                  idle_cnt    <= '0;
               end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                  timeout_o   <= 1'b1;
                  state       <= DRAIN;
               end else begin
                  idle_cnt    <= idle_cnt + TW'(1);
`endif
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mbx_rx_endpoint.sv
// Scoreboard bench for mbx_rx_endpoint: the producer task queues each word it
// offers, and a negedge monitor pops and compares every word the sink takes.
module tb_mbx_rx_endpoint;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [CW-1:0] rcv_count_o;
   logic          busy_o;
   logic          done_o;
`ifdef MBX_RX_TIMEOUT_EN
   logic          timeout_o;
`endif

   always #5 clk = ~clk;

   mbx_rx_endpoint_if #(.DW(8)) bus ();

   mbx_rx_endpoint #(
      .DW        (8),
      .DEPTH     (4),
      .NUM_ITEMS (10)
`ifdef MBX_RX_TIMEOUT_EN
      , .TIMEOUT (16)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .bus         (bus.slave),
      .rcv_count_o (rcv_count_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
`ifdef MBX_RX_TIMEOUT_EN
      , .timeout_o (timeout_o)
`endif
   );

   int         n_checks = 0;
   int         n_errors = 0;
   int         next_cnt = 0;
   int         done_cnt = 0;
   logic       prev_next = 1'b0;
   logic [7:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: acknowledge spacing, sink data order, done only after drain.
   always @(negedge clk) begin
      if (rst) begin
         prev_next = 1'b0;
      end else begin
         if (bus.gen_next_o) begin
            next_cnt++;
            check("ack_back_to_back", prev_next, 0);
         end
         prev_next = bus.gen_next_o;
         if (bus.drv_valid_o && bus.drv_ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_underflow: got word %0h with none expected", bus.drv_data_o);
            end else begin
               check("drv_data", bus.drv_data_o, exp_q.pop_front());
            end
         end
         if (done_o) begin
            done_cnt++;
            check("done_before_drain", exp_q.size(), 0);
         end
      end
   end

   task automatic send_word(input logic [7:0] d);
      bit ok = 0;
      bus.gen_valid_i = 1'b1;
      bus.gen_data_i  = d;
      exp_q.push_back(d);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.gen_next_o) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      check("ack_seen", ok, 1);
   endtask

   task automatic do_start();
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int  start_cnt = done_cnt;
      bit  seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (done_cnt != start_cnt) begin
            seen = 1;
            break;
         end
      end
      check("done_seen", seen, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst             = 1'b0;
      start_i         = 1'b0;
      bus.gen_valid_i = 1'b0;
      bus.gen_data_i  = '0;
      bus.drv_ready_i = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_gen_next", bus.gen_next_o, 0);
      check("rst_drv_valid", bus.drv_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_count", rcv_count_o, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Producer offers a word while idle: must be ignored.
      bus.gen_valid_i = 1'b1;
      bus.gen_data_i  = 8'hAA;
      repeat (6) @(posedge clk);
      #1;
      check("idle_no_ack", next_cnt, 0);
      check("idle_drv_valid", bus.drv_valid_o, 0);
      check("idle_busy", busy_o, 0);
      bus.gen_valid_i = 1'b0;

      // Basic transfer 0x01..0x0A with an always-ready sink.
      bus.drv_ready_i = 1'b1;
      do_start();
      check("basic_busy", busy_o, 1);
      check("basic_count0", rcv_count_o, 0);
      for (int d = 1; d <= 10; d++) send_word(8'(d));
      bus.gen_valid_i = 1'b0;
      wait_done(100);
      repeat (3) @(posedge clk);
      #1;
      check("basic_count", rcv_count_o, 10);
      check("basic_acks", next_cnt, 10);
      check("basic_done_pulses", done_cnt, 1);
      check("basic_sb_empty", exp_q.size(), 0);
      check("basic_idle_busy", busy_o, 0);
      check("basic_drv_valid", bus.drv_valid_o, 0);

      // Backpressure: sink stalled, FIFO fills at 4, then release.
      base = next_cnt;
      bus.drv_ready_i = 1'b0;
      do_start();
      check("bp_count_cleared", rcv_count_o, 0);
      fork
         begin
            for (int d = 8'h11; d <= 8'h1A; d++) send_word(8'(d));
            bus.gen_valid_i = 1'b0;
         end
         begin
            repeat (30) @(posedge clk);
            #1;
            check("bp_acks_at_full", next_cnt - base, 4);
            check("bp_count_at_full", rcv_count_o, 4);
            check("bp_drv_valid", bus.drv_valid_o, 1);
            check("bp_head", bus.drv_data_o, 8'h11);
            check("bp_producer_held", bus.gen_data_i, 8'h15);
            bus.drv_ready_i = 1'b1;
         end
      join
      wait_done(100);
      check("bp_count", rcv_count_o, 10);
      check("bp_acks", next_cnt - base, 10);
      check("bp_sb_empty", exp_q.size(), 0);
      check("bp_done_pulses", done_cnt, 2);

      // Held valid with constant data across acknowledges.
      base = next_cnt;
      do_start();
      for (int i = 0; i < 10; i++) send_word(8'h55);
      bus.gen_valid_i = 1'b0;
      wait_done(100);
      check("held_acks", next_cnt - base, 10);
      check("held_count", rcv_count_o, 10);
      check("held_done_pulses", done_cnt, 3);

      // Reset mid-run after 3 accepts, with a 4th word pending.
      bus.drv_ready_i = 1'b0;
      do_start();
      send_word(8'h21);
      send_word(8'h22);
      send_word(8'h23);
      bus.gen_data_i = 8'h24;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_gen_next", bus.gen_next_o, 0);
      check("mid_rst_drv_valid", bus.drv_valid_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_count", rcv_count_o, 0);
      check("mid_rst_done", done_o, 0);
      exp_q.delete();
      bus.gen_valid_i = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.drv_ready_i = 1'b1;
      do_start();
      check("post_rst_count0", rcv_count_o, 0);
      send_word(8'h31);
      send_word(8'h32);
      check("post_rst_count2", rcv_count_o, 2);
      for (int d = 8'h33; d <= 8'h3A; d++) send_word(8'(d));
      bus.gen_valid_i = 1'b0;
      wait_done(100);
      check("post_rst_count", rcv_count_o, 10);
      check("post_rst_done_pulses", done_cnt, 4);

`ifdef MBX_RX_TIMEOUT_EN
      // Producer stops after 5 words; idle timeout ends the transaction.
      begin
         int  cyc = 0;
         bit  seen = 0;
         do_start();
         for (int d = 8'h41; d <= 8'h45; d++) send_word(8'(d));
         bus.gen_valid_i = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (timeout_o) begin
               seen = 1;
               break;
            end
         end
         check("timeout_seen", seen, 1);
         check("timeout_latency", cyc, 16);
         @(posedge clk);
         #1;
         check("timeout_pulse_width", timeout_o, 0);
         wait_done(100);
         check("timeout_count", rcv_count_o, 5);
         check("timeout_sb_empty", exp_q.size(), 0);
      end
`endif

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
